// File: rtl/mollusc_pkg.sv
// +-----------------------------------------------------------------------+
// | mollusc_pkg: shared widths and the fetch entry type for the pipeline. |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

package mollusc_pkg;

  localparam int PC_W    = 32;
  localparam int INSTR_W = 32;
  localparam logic [PC_W-1:0] PC_STEP = 32'd4;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/fetch_queue.sv
// +-----------------------------------------------------------------------+
// | fetch_queue: DEPTH-entry synchronous FIFO of fetch entries with clear.|
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

module fetch_queue
  import mollusc_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  fetch_entry_t           push_data,
  input  logic                   pop,
  input  logic                   clear,
  output logic [$clog2(DEPTH):0] count,
  output fetch_entry_t           head
);

  localparam int c_aw = $clog2(DEPTH);
  localparam int c_cw = c_aw + 1;

  fetch_entry_t    r_mem [DEPTH];
  logic [c_aw-1:0] r_rd_ptr;
  logic [c_aw-1:0] r_wr_ptr;
  logic [c_cw-1:0] r_count;
  logic            w_do_pop;
  logic            w_do_push;

  // A push into a full queue is legal when the head leaves in the same cycle.
  assign w_do_pop  = pop && (r_count != '0);
  assign w_do_push = push && ((r_count != c_cw'(DEPTH)) || w_do_pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (clear) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= push_data;
        r_wr_ptr        <= r_wr_ptr + c_aw'(1);
      end
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + c_aw'(1);
      r_count <= r_count + c_cw'(w_do_push) - c_cw'(w_do_pop);
    end
  end

  assign count = r_count;
  assign head  = r_mem[r_rd_ptr];

endmodule

`default_nettype wire

// File: rtl/stage_fetch.sv
// +-----------------------------------------------------------------------+
// | stage_fetch: credit-limited instruction fetch with redirect flush.    |
// | Option macro: STAGE_FETCH_ALIGN_CHECK_EN (misaligned redirect fault). |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

module stage_fetch
  import mollusc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        fault
);

  localparam int          c_cw         = $clog2(QDEPTH) + 1;
  localparam logic [31:0] c_align_mask = 32'hFFFF_FFFC;

  logic [PC_W-1:0] r_fetch_pc;
  logic [PC_W-1:0] r_resp_pc;
  logic [c_cw-1:0] r_outstanding;
  logic [c_cw-1:0] r_discard;
  logic [c_cw-1:0] w_outstanding_next;
  logic [c_cw-1:0] q_count;
  logic [c_cw:0]   w_in_use;
  logic [PC_W-1:0] w_redirect_pc;
  logic            w_fault;
  logic            w_req_fire;
  logic            w_push;
  logic            w_pop;
  fetch_entry_t    w_push_data;
  fetch_entry_t    q_head;

  assign w_redirect_pc = redirect_pc & c_align_mask;

`ifdef STAGE_FETCH_ALIGN_CHECK_EN
  localparam logic [0:0] c_st_run   = 1'b0;
  localparam logic [0:0] c_st_fault = 1'b1;

  logic [0:0] r_state;
  logic [0:0] w_state_next;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= c_st_run;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (redirect) w_state_next = (redirect_pc[1:0] != 2'b00) ? c_st_fault : c_st_run;
  end

  always_comb begin
    w_fault = (r_state == c_st_fault);
  end
`else
  assign w_fault = 1'b0;
`endif

  // Requests only while every in-flight word is guaranteed a queue slot.
  assign w_in_use      = {1'b0, r_outstanding} + {1'b0, q_count};
  assign mem_req_valid = rst_n && !redirect && !w_fault && (w_in_use < (c_cw + 1)'(QDEPTH));
  assign mem_req_addr  = r_fetch_pc;
  assign w_req_fire    = mem_req_valid && mem_req_ready;

  assign w_outstanding_next = r_outstanding + c_cw'(w_req_fire) - c_cw'(mem_resp_valid);

  assign w_push      = mem_resp_valid && !redirect && !w_fault && (r_discard == '0);
  assign w_push_data = '{pc: r_resp_pc, instr: mem_resp_data};
  assign w_pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fetch_pc    <= RESET_PC & c_align_mask;
      r_resp_pc     <= RESET_PC & c_align_mask;
      r_outstanding <= '0;
      r_discard     <= '0;
    end else begin
      r_outstanding <= w_outstanding_next;
      if (redirect) begin
        r_fetch_pc <= w_redirect_pc;
        r_resp_pc  <= w_redirect_pc;
        r_discard  <= w_outstanding_next;
      end else begin
        if (w_req_fire) r_fetch_pc <= r_fetch_pc + PC_STEP;
        if (w_push)     r_resp_pc  <= r_resp_pc + PC_STEP;
        if (mem_resp_valid && (r_discard != '0)) r_discard <= r_discard - c_cw'(1);
      end
    end
  end

  fetch_queue #(
    .DEPTH (QDEPTH)
  ) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_push),
    .push_data (w_push_data),
    .pop       (w_pop),
    .clear     (redirect),
    .count     (q_count),
    .head      (q_head)
  );

  assign out_valid = (q_count != '0) && !w_fault;
  assign out_pc    = q_head.pc;
  assign out_instr = q_head.instr;
  assign fault     = w_fault;

endmodule

`default_nettype wire

// File: tb/tb_stage_fetch.sv
// +-----------------------------------------------------------------------+
// | tb_stage_fetch: directed bench with an in-order memory model.         |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_stage_fetch;

  localparam logic [31:0] c_reset_pc = 32'h0000_0100;
  localparam int          c_qdepth   = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        fault;

  int          n_cmp = 0;
  int          n_err = 0;
  int          n_pop = 0;
  int          n_req = 0;
  logic [31:0] exp_pc;

  always #5 clk = ~clk;

  stage_fetch #(
    .RESET_PC (c_reset_pc),
    .QDEPTH   (c_qdepth)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .fault          (fault)
  );

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  // In-order memory: each accepted address answers no earlier than next cycle.
  logic [31:0] mq [16];
  logic [3:0]  m_wp;
  logic [3:0]  m_rp;
  logic        resp_en;

  assign mem_resp_valid = resp_en && (m_wp != m_rp);
  assign mem_resp_data  = instr_of(mq[m_rp]);

  always @(posedge clk) begin
    if (!rst_n) begin
      m_wp <= '0;
      m_rp <= '0;
    end else begin
      if (mem_req_valid && mem_req_ready) begin
        mq[m_wp] <= mem_req_addr;
        m_wp     <= m_wp + 4'd1;
      end
      if (mem_resp_valid) m_rp <= m_rp + 4'd1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Samples the cycle just before its rising edge, then advances to the next falling edge.
  task automatic tick();
    #1;
    if (out_valid && out_ready && !redirect) begin
      check_eq("seq_pc", out_pc, exp_pc);
      check_eq("seq_instr", out_instr, instr_of(exp_pc));
      exp_pc = exp_pc + 32'd4;
      n_pop++;
    end
    if (mem_req_valid && mem_req_ready) n_req++;
    if (redirect) exp_pc = redirect_pc & 32'hFFFF_FFFC;
    @(negedge clk);
  endtask

  task automatic run_pops(input int n, input string tag);
    int start;
    start = n_pop;
    for (int i = 0; i < 60 && (n_pop - start) < n; i++) tick();
    check_eq(tag, 32'(n_pop - start), 32'(n));
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    redirect    = 1'b1;
    redirect_pc = pc;
    tick();
    redirect    = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int snap;
    bit found;
    rst_n         = 1'b0;
    mem_req_ready = 1'b1;
    resp_en       = 1'b1;
    redirect      = 1'b0;
    redirect_pc   = 32'h0;
    out_ready     = 1'b1;
    exp_pc        = c_reset_pc;

    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_req_valid", 32'(mem_req_valid), 32'd0);
    check_eq("rst_req_addr", mem_req_addr, 32'h0000_0100);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_pc", out_pc, 32'h0);
    check_eq("rst_out_instr", out_instr, 32'h0);
    check_eq("rst_fault", 32'(fault), 32'd0);

    rst_n = 1'b1;
    #1;
    check_eq("first_req_valid", 32'(mem_req_valid), 32'd1);
    check_eq("first_req_addr", mem_req_addr, 32'h0000_0100);
    run_pops(4, "seq_from_reset");

    // Decode stall: credit must cap requests and hold the head steady.
    out_ready = 1'b0;
    snap = n_req;
    repeat (10) tick();
    #1;
    check_eq("stall_req_cap", 32'((n_req - snap) <= c_qdepth), 32'd1);
    check_eq("stall_req_valid", 32'(mem_req_valid), 32'd0);
    check_eq("stall_out_valid", 32'(out_valid), 32'd1);
    check_eq("stall_out_pc", out_pc, 32'h0000_0110);
    out_ready = 1'b1;
    run_pops(4, "stall_drain");

    // Two requests left in flight, then redirect.
    resp_en = 1'b0;
    repeat (6) tick();
    #1;
    check_eq("inflight_credit", 32'(mem_req_valid), 32'd0);
    do_redirect(32'h0000_2000);
    #1;
    check_eq("redir_addr", mem_req_addr, 32'h0000_2000);
    check_eq("redir_credit", 32'(mem_req_valid), 32'd0);
    resp_en = 1'b1;
    run_pops(3, "redir_seq");

    // Redirect coinciding with a pop and a response.
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      #1;
      if (out_valid && mem_resp_valid) found = 1'b1;
      else tick();
    end
    check_eq("collide_found", 32'(found), 32'd1);
    do_redirect(32'h0000_3000);
    #1;
    check_eq("collide_empty", 32'(out_valid), 32'd0);
    check_eq("collide_addr", mem_req_addr, 32'h0000_3000);
    run_pops(2, "collide_seq");

    do_redirect(32'hFFFF_FFF8);
    run_pops(3, "wrap_seq");
    check_eq("wrap_next", exp_pc, 32'h0000_0004);

`ifdef STAGE_FETCH_ALIGN_CHECK_EN
    do_redirect(32'h0000_1002);
    #1;
    check_eq("fault_set", 32'(fault), 32'd1);
    check_eq("fault_noreq", 32'(mem_req_valid), 32'd0);
    check_eq("fault_noout", 32'(out_valid), 32'd0);
    snap = n_req;
    repeat (3) tick();
    check_eq("fault_reqs", 32'(n_req - snap), 32'd0);
    do_redirect(32'h0000_1004);
    #1;
    check_eq("fault_clear", 32'(fault), 32'd0);
    check_eq("fault_req_valid", 32'(mem_req_valid), 32'd1);
    check_eq("fault_req_addr", mem_req_addr, 32'h0000_1004);
    run_pops(2, "fault_seq");
`else
    do_redirect(32'h0000_1002);
    #1;
    check_eq("align_fault", 32'(fault), 32'd0);
    check_eq("align_addr", mem_req_addr, 32'h0000_1000);
    run_pops(2, "align_seq");
    do_redirect(32'h0000_1004);
    #1;
    check_eq("align_fault2", 32'(fault), 32'd0);
    check_eq("align_req_addr", mem_req_addr, 32'h0000_1004);
    run_pops(2, "align_seq2");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
